// File: rtl/ccff_chain_loader.sv
`default_nettype none
// ============================================================================
//  Module      : ccff_chain_loader
//  Description : Probes a tile's configuration chain for its length, then
//                serialises host config words onto ccff_head.
//  Revision    : 1.0 - initial release
// ============================================================================
module ccff_chain_loader #(
    parameter int CHAIN_LEN = 32,
    parameter int WORD_W    = 8,
    parameter int CNT_W     = 16
) (
    input  logic              prog_clk,
    input  logic              prog_rst_n,
    input  logic              start,
    input  logic [WORD_W-1:0] cfg_data,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    output logic              ccff_head,
    input  logic              ccff_tail,
    output logic              ccff_shift_en,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [CNT_W-1:0]  chain_len_meas
);

    localparam int REM_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam logic [CNT_W-1:0] C_LEN     = CNT_W'(CHAIN_LEN);
    localparam logic [CNT_W-1:0] C_LEN2    = CNT_W'(2 * CHAIN_LEN);
    localparam logic [REM_W-1:0] C_REM_NEW = REM_W'(WORD_W - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FLUSH = 3'd1,
        S_PROBE = 3'd2,
        S_LOAD  = 3'd3,
        S_DONE  = 3'd4,
        S_ERR   = 3'd5
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [REM_W-1:0]   rem_q, rem_d;
    logic [WORD_W-1:0]  buf_q, buf_d;
    logic               head_q, head_d;
    logic               shift_en_q, shift_en_d;
    logic [CNT_W-1:0]   meas_q, meas_d;

    logic [CNT_W-1:0]   w_cnt_inc;
    logic               w_ready;
    logic               w_accept;

    // cnt_q counts shift edges of the current phase; w_cnt_inc includes the edge now ending
    assign w_cnt_inc = cnt_q + {{(CNT_W-1){1'b0}}, shift_en_q};
    assign w_ready   = (state_q == S_LOAD) && (rem_q == '0) && (w_cnt_inc < C_LEN);
    assign w_accept  = w_ready && cfg_valid;

    always_ff @(posedge prog_clk or negedge prog_rst_n) begin
        if (!prog_rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            rem_q      <= '0;
            buf_q      <= '0;
            head_q     <= 1'b0;
            shift_en_q <= 1'b0;
            meas_q     <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rem_q      <= rem_d;
            buf_q      <= buf_d;
            head_q     <= head_d;
            shift_en_q <= shift_en_d;
            meas_q     <= meas_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rem_d      = rem_q;
        buf_d      = buf_q;
        head_d     = head_q;
        shift_en_d = shift_en_q;
        meas_d     = meas_q;

        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                shift_en_d = 1'b0;
                head_d     = 1'b0;
                if (start) begin
                    state_d    = S_FLUSH;
                    cnt_d      = '0;
                    rem_d      = '0;
                    buf_d      = '0;
                    meas_d     = '0;
                    shift_en_d = 1'b1;
                end
            end

            S_FLUSH: begin
                cnt_d = w_cnt_inc;
                if (w_cnt_inc == C_LEN) begin
                    state_d    = S_PROBE;
                    cnt_d      = '0;
                    head_d     = 1'b1;
                    shift_en_d = 1'b1;
                end
            end

            S_PROBE: begin
                head_d = 1'b0;
                if ((cnt_q != '0) && ccff_tail) begin
                    meas_d     = cnt_q;
                    cnt_d      = '0;
                    rem_d      = '0;
                    shift_en_d = 1'b0;
                    state_d    = (cnt_q == C_LEN) ? S_LOAD : S_ERR;
                end else if (!shift_en_q && (cnt_q == C_LEN2)) begin
                    meas_d     = '0;
                    shift_en_d = 1'b0;
                    state_d    = S_ERR;
                end else begin
                    // Pause one cycle after edge N and edge 2N so the tail can be
                    // checked without a further edge disturbing a correct chain.
                    cnt_d      = w_cnt_inc;
                    shift_en_d = !(shift_en_q && ((w_cnt_inc == C_LEN) || (w_cnt_inc == C_LEN2)));
                end
            end

            S_LOAD: begin
                if (shift_en_q && (w_cnt_inc == C_LEN)) begin
                    cnt_d      = w_cnt_inc;
                    state_d    = S_DONE;
                    shift_en_d = 1'b0;
                    head_d     = 1'b0;
                    rem_d      = '0;
                    buf_d      = '0;
                end else if (shift_en_q && (rem_q != '0)) begin
                    cnt_d  = w_cnt_inc;
                    head_d = buf_q[0];
                    buf_d  = buf_q >> 1;
                    rem_d  = rem_q - REM_W'(1);
                end else if (w_accept) begin
                    cnt_d      = w_cnt_inc;
                    head_d     = cfg_data[0];
                    buf_d      = cfg_data >> 1;
                    rem_d      = C_REM_NEW;
                    shift_en_d = 1'b1;
                end else begin
                    cnt_d      = w_cnt_inc;
                    shift_en_d = 1'b0;
                end
            end

            default: begin
                state_d    = S_IDLE;
                shift_en_d = 1'b0;
                head_d     = 1'b0;
            end
        endcase
    end

    assign cfg_ready      = w_ready;
    assign ccff_head      = head_q;
    assign ccff_shift_en  = shift_en_q;
    assign busy           = (state_q == S_FLUSH) || (state_q == S_PROBE) || (state_q == S_LOAD);
    assign done           = (state_q == S_DONE);
    assign error          = (state_q == S_ERR);
    assign chain_len_meas = meas_q;

endmodule
`default_nettype wire

// File: tb/tb_ccff_chain_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ccff_chain_loader
//  Description : Self-checking bench: two loaders (32- and 30-FF chains) driving
//                behavioural shift-register chains, checked against a bitstream model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ccff_chain_loader;

    localparam int N_A = 32;
    localparam int N_B = 30;
    localparam int W   = 8;
    localparam int CW  = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          a_start = 1'b0, a_valid = 1'b0;
    logic [W-1:0]  a_data  = '0;
    logic          a_ready, a_head, a_tail, a_sen, a_busy, a_done, a_err;
    logic [CW-1:0] a_meas;

    logic          b_start = 1'b0, b_valid = 1'b0;
    logic [W-1:0]  b_data  = '0;
    logic          b_ready, b_head, b_tail, b_sen, b_busy, b_done, b_err;
    logic [CW-1:0] b_meas;

    ccff_chain_loader #(.CHAIN_LEN(N_A), .WORD_W(W), .CNT_W(CW)) u_dut_a (
        .prog_clk(clk), .prog_rst_n(rst_n), .start(a_start), .cfg_data(a_data),
        .cfg_valid(a_valid), .cfg_ready(a_ready), .ccff_head(a_head), .ccff_tail(a_tail),
        .ccff_shift_en(a_sen), .busy(a_busy), .done(a_done), .error(a_err),
        .chain_len_meas(a_meas)
    );

    ccff_chain_loader #(.CHAIN_LEN(N_B), .WORD_W(W), .CNT_W(CW)) u_dut_b (
        .prog_clk(clk), .prog_rst_n(rst_n), .start(b_start), .cfg_data(b_data),
        .cfg_valid(b_valid), .cfg_ready(b_ready), .ccff_head(b_head), .ccff_tail(b_tail),
        .ccff_shift_en(b_sen), .busy(b_busy), .done(b_done), .error(b_err),
        .chain_len_meas(b_meas)
    );

    // Physical chains: FF[0] nearest ccff_head, tail taken from the last physical FF
    logic [63:0] a_chain = '0;
    logic [63:0] b_chain = '0;
    logic [5:0]  a_tail_idx = 6'd31;
    logic        a_stuck = 1'b0;
    always @(posedge clk) if (a_sen) a_chain <= {a_chain[62:0], a_head};
    always @(posedge clk) if (b_sen) b_chain <= {b_chain[62:0], b_head};
    assign a_tail = a_stuck ? 1'b0 : a_chain[a_tail_idx];
    assign b_tail = b_chain[N_B-1];

    bit            sel = 1'b0;
    logic          s_ready, s_head, s_sen, s_busy, s_done, s_err;
    logic [CW-1:0] s_meas;
    always_comb begin
        s_ready = sel ? b_ready : a_ready;
        s_head  = sel ? b_head  : a_head;
        s_sen   = sel ? b_sen   : a_sen;
        s_busy  = sel ? b_busy  : a_busy;
        s_done  = sel ? b_done  : a_done;
        s_err   = sel ? b_err   : a_err;
        s_meas  = sel ? b_meas  : a_meas;
    end

    int n_checks = 0;
    int n_fail   = 0;
    logic [W-1:0] words[$];
    int edges, stalls, accepted, ready_seen;
    bit timed_out;
    int base_stalls;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_in(input logic st, input logic v, input logic [W-1:0] d);
        a_start = sel ? 1'b0 : st;
        a_valid = sel ? 1'b0 : v;
        a_data  = d;
        b_start = sel ? st : 1'b0;
        b_valid = sel ? v : 1'b0;
        b_data  = d;
    endtask

    // Expected chain image: stream bit k lands in FF[n-1-k]
    function automatic logic [63:0] ref_image(input int n);
        logic [63:0] img;
        logic [W-1:0] wd;
        img = '0;
        for (int k = 0; k < n; k++) begin
            wd = words[k / W];
            img[n-1-k] = wd[k % W];
        end
        return img;
    endfunction

    task automatic check_image(input string tag, input int n);
        logic [63:0] mask;
        logic [63:0] obs;
        mask = (64'd1 << n) - 64'd1;
        obs  = (sel ? b_chain : a_chain) & mask;
        chk(tag, obs, ref_image(n));
    endtask

    // Host side: start pulse, then offer words; valid withheld for gap_len ready cycles
    // before word gap_word. Stops at done/error, at the reset point, or on timeout.
    task automatic run(input int gap_word, input int gap_len, input int reset_at_edge);
        int idx, gap, cyc;
        bit v;
        idx = 0; gap = 0; cyc = 0;
        edges = 0; stalls = 0; accepted = 0; ready_seen = 0; timed_out = 1'b0;
        @(negedge clk); set_in(1'b1, 1'b0, '0);
        @(negedge clk); set_in(1'b0, 1'b0, '0);
        while (!(s_done || s_err)) begin
            if (cyc > 3000) begin
                timed_out = 1'b1;
                break;
            end
            v = (idx < words.size()) && !((idx == gap_word) && (gap < gap_len));
            set_in(1'b0, v, v ? words[idx] : W'($urandom));
            if (s_ready && (idx == gap_word) && (gap < gap_len)) gap++;
            if (s_ready) ready_seen++;
            if (v && s_ready) begin
                accepted++;
                idx++;
            end
            if (s_sen) edges++;
            if (s_busy && !s_sen) stalls++;
            if ((reset_at_edge > 0) && (edges == reset_at_edge)) break;
            @(negedge clk);
            cyc++;
        end
        set_in(1'b0, 1'b0, '0);
    endtask

    task automatic check_quiet(input string tag);
        repeat (3) begin
            @(negedge clk);
            chk({tag, "_sen"},   64'(s_sen),   64'd0);
            chk({tag, "_ready"}, 64'(s_ready), 64'd0);
            chk({tag, "_head"},  64'(s_head),  64'd0);
        end
    endtask

    task automatic async_reset_check(input string tag);
        @(posedge clk); #2 rst_n = 1'b0; #1;
        chk({tag, "_head"},  64'(s_head),  64'd0);
        chk({tag, "_sen"},   64'(s_sen),   64'd0);
        chk({tag, "_busy"},  64'(s_busy),  64'd0);
        chk({tag, "_done"},  64'(s_done),  64'd0);
        chk({tag, "_err"},   64'(s_err),   64'd0);
        chk({tag, "_ready"}, 64'(s_ready), 64'd0);
        chk({tag, "_meas"},  64'(s_meas),  64'd0);
        @(negedge clk); rst_n = 1'b1;
    endtask

    initial begin
        set_in(1'b0, 1'b0, '0);
        repeat (3) @(negedge clk);
        sel = 1'b1;
        chk("por_b_sen",  64'(s_sen),  64'd0);
        chk("por_b_busy", 64'(s_busy), 64'd0);
        sel = 1'b0;
        chk("por_a_head", 64'(s_head), 64'd0);
        chk("por_a_done", 64'(s_done), 64'd0);
        rst_n = 1'b1;

        // Reset asserted mid-cycle during FLUSH
        @(negedge clk); set_in(1'b1, 1'b0, '0);
        @(negedge clk); set_in(1'b0, 1'b0, '0);
        repeat (10) @(negedge clk);
        chk("flush_busy", 64'(s_busy), 64'd1);
        chk("flush_sen",  64'(s_sen),  64'd1);
        async_reset_check("rst_flush");

        // N=32, four fixed words back-to-back, a fifth offered but never taken
        words = '{8'hA5, 8'h3C, 8'hFF, 8'h00, 8'h5A};
        run(-1, 0, 0);
        base_stalls = stalls;
        chk("s2_timeout",  64'(timed_out), 64'd0);
        chk("s2_done",     64'(s_done),    64'd1);
        chk("s2_err",      64'(s_err),     64'd0);
        chk("s2_meas",     64'(s_meas),    64'(N_A));
        chk("s2_edges",    64'(edges),     64'(3 * N_A));
        chk("s2_accepted", 64'(accepted),  64'd4);
        check_image("s2_image", N_A);
        check_quiet("s2_hold");

        // Host withholds word 3 for 5 ready cycles
        run(2, 5, 0);
        chk("s5_done",   64'(s_done), 64'd1);
        chk("s5_edges",  64'(edges),  64'(3 * N_A));
        chk("s5_stalls", 64'(stalls), 64'(base_stalls + 5));
        check_image("s5_image", N_A);

        // Chain one FF short
        a_tail_idx = 6'd30;
        run(-1, 0, 0);
        chk("s3_timeout", 64'(timed_out),  64'd0);
        chk("s3_err",     64'(s_err),      64'd1);
        chk("s3_done",    64'(s_done),     64'd0);
        chk("s3_meas",    64'(s_meas),     64'd31);
        chk("s3_ready",   64'(ready_seen), 64'd0);
        check_quiet("s3_hold");

        // Tail stuck at 0: 32 flush + 64 probe edges, no length found
        a_tail_idx = 6'd31;
        a_stuck    = 1'b1;
        run(-1, 0, 0);
        chk("s4_err",   64'(s_err),      64'd1);
        chk("s4_meas",  64'(s_meas),     64'd0);
        chk("s4_edges", 64'(edges),      64'(3 * N_A));
        chk("s4_ready", 64'(ready_seen), 64'd0);
        a_stuck = 1'b0;

        // Random bitstreams and host gaps on the 32-FF chain
        for (int it = 0; it < 4; it++) begin
            words.delete();
            for (int i = 0; i < 5; i++) words.push_back(W'($urandom));
            run(int'($urandom_range(0, 3)), int'($urandom_range(0, 6)), 0);
            chk("rnd_done",     64'(s_done),   64'd1);
            chk("rnd_meas",     64'(s_meas),   64'(N_A));
            chk("rnd_edges",    64'(edges),    64'(3 * N_A));
            chk("rnd_accepted", 64'(accepted), 64'd4);
            check_image("rnd_image", N_A);
        end

        // CHAIN_LEN=30: last two bits of word 4 are dropped
        sel = 1'b1;
        words.delete();
        for (int i = 0; i < 4; i++) words.push_back(W'($urandom));
        run(-1, 0, 0);
        chk("s6_done",     64'(s_done),   64'd1);
        chk("s6_meas",     64'(s_meas),   64'(N_B));
        chk("s6_edges",    64'(edges),    64'(3 * N_B));
        chk("s6_accepted", 64'(accepted), 64'd4);
        check_image("s6_image", N_B);

        // Reset after 12 LOAD bits, then a clean reload
        words.delete();
        for (int i = 0; i < 4; i++) words.push_back(W'($urandom));
        run(-1, 0, 2 * N_B + 12);
        chk("s6_pre_rst_busy", 64'(s_busy), 64'd1);
        async_reset_check("s6_rst");
        words.delete();
        for (int i = 0; i < 4; i++) words.push_back(W'($urandom));
        run(-1, 0, 0);
        chk("s6r_timeout", 64'(timed_out), 64'd0);
        chk("s6r_done",    64'(s_done),    64'd1);
        chk("s6r_edges",   64'(edges),     64'(3 * N_B));
        check_image("s6r_image", N_B);
        check_quiet("s6r_hold");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
